// File: rtl/memory_island_burst_issuer.sv
// Burst issuer for one wide port of the memory island: turns a burst command
// into per-beat req/gnt transactions, forwards read responses with a last
// flag, swallows write responses and reports write-burst completion.
module memory_island_burst_issuer #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned MaxBeats       = 256,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned LenWidth       = $clog2(MaxBeats),
  parameter int unsigned StrbWidth      = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic                 cmd_we_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [StrbWidth-1:0] wstrb_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [StrbWidth-1:0] mem_strb_o,
  input  logic                 mem_rvalid_i,
  output logic                 mem_rready_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 rdata_valid_o,
  input  logic                 rdata_ready_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rdata_last_o,
  output logic                 wdone_valid_o,
  input  logic                 wdone_ready_i
);

  localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned CntWidth = LenWidth + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WDONE = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [AddrWidth-1:0] addr;
  logic [LenWidth-1:0]  len;
  logic                 we;
  logic [CntWidth-1:0]  issue_cnt;
  logic [CntWidth-1:0]  rsp_cnt;
  logic [CntWidth-1:0]  rsp_cnt_nxt;
  logic [OutWidth-1:0]  outstanding;
  logic                 cmd_fire;
  logic                 issue_fire;
  logic                 rsp_fire;

  // Next-state, handshake and response-path decode; everything forced low in reset
  always_comb begin
    state_nxt     = state;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    mem_req_o     = 1'b0;
    mem_rready_o  = 1'b0;
    rdata_valid_o = 1'b0;
    rdata_last_o  = 1'b0;
    wdone_valid_o = 1'b0;
    cmd_fire      = 1'b0;
    issue_fire    = 1'b0;
    rsp_fire      = 1'b0;
    rsp_cnt_nxt   = rsp_cnt;

    case (state)
      IDLE: begin
        // Stray responses (e.g. after a mid-burst reset) are accepted and dropped
        cmd_ready_o  = 1'b1;
        mem_rready_o = 1'b1;
        if (cmd_valid_i) begin
          cmd_fire  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE, DRAIN: begin
        if (state == ISSUE) begin
          mem_req_o = (~we | wdata_valid_i) & (outstanding < OutWidth'(MaxOutstanding));
        end
        if (we) begin
          mem_rready_o = 1'b1;
        end else begin
          rdata_valid_o = mem_rvalid_i;
          mem_rready_o  = rdata_ready_i;
          rdata_last_o  = mem_rvalid_i & (rsp_cnt == CntWidth'(len));
        end
        rsp_fire      = mem_rvalid_i & mem_rready_o;
        issue_fire    = mem_req_o & mem_gnt_i;
        wdata_ready_o = we & issue_fire;
        rsp_cnt_nxt   = rsp_cnt + CntWidth'(rsp_fire);
        if (state == ISSUE) begin
          if (issue_fire && (issue_cnt == CntWidth'(len))) begin
            state_nxt = DRAIN;
          end
        end else if (rsp_cnt_nxt == (CntWidth'(len) + CntWidth'(1))) begin
          state_nxt = we ? WDONE : IDLE;
        end
      end
      WDONE: begin
        wdone_valid_o = 1'b1;
        if (wdone_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (rst_i) begin
      cmd_ready_o   = 1'b0;
      wdata_ready_o = 1'b0;
      mem_req_o     = 1'b0;
      mem_rready_o  = 1'b0;
      rdata_valid_o = 1'b0;
      rdata_last_o  = 1'b0;
      wdone_valid_o = 1'b0;
      cmd_fire      = 1'b0;
      issue_fire    = 1'b0;
      rsp_fire      = 1'b0;
    end
  end

  // Payload pass-through, held at zero while in reset
  always_comb begin
    mem_addr_o  = rst_i ? '0 : addr;
    mem_we_o    = ~rst_i & we;
    mem_wdata_o = rst_i ? '0 : wdata_i;
    mem_strb_o  = rst_i ? '0 : wstrb_i;
    rdata_o     = rst_i ? '0 : mem_rdata_i;
  end

  // State register plus burst address, beat and outstanding counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      addr        <= '0;
      len         <= '0;
      we          <= 1'b0;
      issue_cnt   <= '0;
      rsp_cnt     <= '0;
      outstanding <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        addr        <= cmd_addr_i & ~(AddrWidth'(StrbWidth - 1));
        len         <= cmd_len_i;
        we          <= cmd_we_i;
        issue_cnt   <= '0;
        rsp_cnt     <= '0;
        outstanding <= '0;
      end else begin
        if (issue_fire) begin
          addr      <= addr + AddrWidth'(StrbWidth);
          issue_cnt <= issue_cnt + CntWidth'(1);
        end
        rsp_cnt <= rsp_cnt_nxt;
        case ({issue_fire, rsp_fire})
          2'b10:   outstanding <= outstanding + OutWidth'(1);
          2'b01:   outstanding <= outstanding - OutWidth'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_island_burst_issuer.sv
// Directed self-checking bench for memory_island_burst_issuer.
module tb_memory_island_burst_issuer;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 512;
  localparam int unsigned LenWidth  = 8;
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [AddrWidth-1:0] cmd_addr_i;
  logic [LenWidth-1:0]  cmd_len_i;
  logic                 cmd_we_i;
  logic                 wdata_valid_i;
  logic                 wdata_ready_o;
  logic [DataWidth-1:0] wdata_i;
  logic [StrbWidth-1:0] wstrb_i;
  logic                 mem_req_o;
  logic                 mem_gnt_i;
  logic [AddrWidth-1:0] mem_addr_o;
  logic                 mem_we_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic [StrbWidth-1:0] mem_strb_o;
  logic                 mem_rvalid_i;
  logic                 mem_rready_o;
  logic [DataWidth-1:0] mem_rdata_i;
  logic                 rdata_valid_o;
  logic                 rdata_ready_i;
  logic [DataWidth-1:0] rdata_o;
  logic                 rdata_last_o;
  logic                 wdone_valid_o;
  logic                 wdone_ready_i;

  int checks   = 0;
  int failures = 0;

  memory_island_burst_issuer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .cmd_we_i      (cmd_we_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .wdata_i       (wdata_i),
    .wstrb_i       (wstrb_i),
    .mem_req_o     (mem_req_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_strb_o    (mem_strb_o),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rready_o  (mem_rready_o),
    .mem_rdata_i   (mem_rdata_i),
    .rdata_valid_o (rdata_valid_o),
    .rdata_ready_i (rdata_ready_i),
    .rdata_o       (rdata_o),
    .rdata_last_o  (rdata_last_o),
    .wdone_valid_o (wdone_valid_o),
    .wdone_ready_i (wdone_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{cmd_ready_o, wdata_ready_o, mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
             mem_strb_o, mem_rready_o, rdata_valid_o, rdata_o, rdata_last_o, wdone_valid_o};
  endfunction

  // Advance to just after the next rising edge; inputs are driven from here
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input int len, input logic we);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_len_i   = LenWidth'(len);
    cmd_we_i    = we;
    #1;
    check("cmd_ready", cmd_ready_o, 1);
    step();
    cmd_valid_i = 1'b0;
  endtask

  // Read burst with grant always high and each response one cycle after its grant
  task automatic run_read(input logic [31:0] addr, input int len, input logic [31:0] exp_first);
    int ngr = 0;
    int nrsp = 0;
    bit pend = 0;
    bit done = 0;
    send_cmd(addr, len, 1'b0);
    mem_gnt_i     = 1'b1;
    rdata_ready_i = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_rvalid_i = pend;
      mem_rdata_i  = DataWidth'(64'hBEEF_0000 + 64'(nrsp));
      #1;
      if (cmd_ready_o && nrsp == len + 1) begin
        done = 1;
      end else begin
        if (mem_req_o && mem_gnt_i) begin
          check("rd_addr", 64'(mem_addr_o), 64'(32'(exp_first + 32'(ngr * 64))));
          ngr++;
        end
        if (rdata_valid_o) begin
          check("rd_data", rdata_o[63:0], 64'hBEEF_0000 + 64'(nrsp));
          check("rd_last", 64'(rdata_last_o), 64'(nrsp == len));
          nrsp++;
        end
        pend = mem_req_o && mem_gnt_i;
        step();
      end
    end
    check("rd_done_idle", 64'(done), 1);
    check("rd_grants", 64'(ngr), 64'(len + 1));
    check("rd_beats", 64'(nrsp), 64'(len + 1));
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nlast;
    int nbeats;
    bit done;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; cmd_we_i = 1'b0;
    wdata_valid_i = 1'b0; wdata_i = '0; wstrb_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    rdata_ready_i = 1'b0; wdone_ready_i = 1'b0;
    repeat (3) step();

    // Reset: every output low even with live inputs
    wdata_i = '1; wstrb_i = '1; mem_rvalid_i = 1'b1; mem_rdata_i = '1;
    rdata_ready_i = 1'b1; wdata_valid_i = 1'b1;
    #1;
    check("rst_outs", 64'(any_out()), 0);
    rst_i = 1'b0; mem_rvalid_i = 1'b0; wdata_valid_i = 1'b0;
    wdata_i = '0; wstrb_i = '0; mem_rdata_i = '0;
    step();
    #1;
    check("idle_cmd_ready", 64'(cmd_ready_o), 1);
    check("idle_rready", 64'(mem_rready_o), 1);
    check("idle_noreq", 64'(mem_req_o), 0);

    // Read burst of 4 beats at 0x1000
    run_read(32'h0000_1000, 3, 32'h0000_1000);

    // Write burst of 2 beats with write data late by 3 cycles
    send_cmd(32'h0000_3000, 1, 1'b1);
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wr_noreq", 64'(mem_req_o), 0);
      step();
    end
    wdata_valid_i = 1'b1; wdata_i = DataWidth'(64'h1111); wstrb_i = '1;
    #1;
    check("wr_req0", 64'(mem_req_o), 1);
    check("wr_we0", 64'(mem_we_o), 1);
    check("wr_addr0", 64'(mem_addr_o), 64'h3000);
    check("wr_wdata0", mem_wdata_o[63:0], 64'h1111);
    check("wr_wready0", 64'(wdata_ready_o), 1);
    step();
    wdata_i = DataWidth'(64'h2222); mem_rvalid_i = 1'b1;
    #1;
    check("wr_req1", 64'(mem_req_o), 1);
    check("wr_addr1", 64'(mem_addr_o), 64'h3040);
    check("wr_wdata1", mem_wdata_o[63:0], 64'h2222);
    check("wr_rsp_rready", 64'(mem_rready_o), 1);
    check("wr_rsp_swallow", 64'(rdata_valid_o), 0);
    step();
    wdata_valid_i = 1'b0;
    #1;
    check("wr_drain_noreq", 64'(mem_req_o), 0);
    check("wr_drain_wready", 64'(wdata_ready_o), 0);
    check("wr_drain_swallow", 64'(rdata_valid_o), 0);
    check("wr_drain_nodone", 64'(wdone_valid_o), 0);
    step();
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("wdone_held", 64'(wdone_valid_o), 1);
      check("wdone_cmd_blocked", 64'(cmd_ready_o), 0);
      step();
    end
    wdone_ready_i = 1'b1;
    #1;
    check("wdone_valid", 64'(wdone_valid_o), 1);
    step();
    wdone_ready_i = 1'b0;
    #1;
    check("wdone_cleared", 64'(wdone_valid_o), 0);
    check("wdone_idle", 64'(cmd_ready_o), 1);

    // Outstanding limit: read of 8 beats with responses withheld
    send_cmd(32'h0000_4000, 7, 1'b0);
    mem_gnt_i = 1'b1; rdata_ready_i = 1'b1; mem_rvalid_i = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (mem_req_o && mem_gnt_i) n++;
      step();
    end
    check("os_grants", 64'(n), 4);
    #1;
    check("os_stall", 64'(mem_req_o), 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = DataWidth'(64'h55);
    #1;
    check("os_rel_valid", 64'(rdata_valid_o), 1);
    check("os_rel_noreq", 64'(mem_req_o), 0);
    step();
    mem_rvalid_i = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (mem_req_o && mem_gnt_i) n++;
      step();
    end
    check("os_one_more", 64'(n), 1);

    // Backpressure: response held while rdata_ready_i is low
    mem_rvalid_i = 1'b1; rdata_ready_i = 1'b0; mem_rdata_i = DataWidth'(64'hABCD);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rready", 64'(mem_rready_o), 0);
      check("bp_valid", 64'(rdata_valid_o), 1);
      check("bp_data", rdata_o[63:0], 64'hABCD);
      check("bp_noreq", 64'(mem_req_o), 0);
      step();
    end
    rdata_ready_i = 1'b1;
    #1;
    check("bp_accept", 64'(mem_rready_o), 1);
    check("bp_notlast", 64'(rdata_last_o), 0);
    step();
    // Grant and response together: outstanding stays at 3
    #1;
    check("sc_req", 64'(mem_req_o), 1);
    step();
    mem_rvalid_i = 1'b0;
    #1;
    check("sc_req_after", 64'(mem_req_o), 1);
    step();
    #1;
    check("sc_full_again", 64'(mem_req_o), 0);
    // Finish the burst with continuous responses
    mem_rvalid_i = 1'b1;
    nlast = 0; nbeats = 0; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      mem_rdata_i = DataWidth'(64'h900 + 64'(c));
      #1;
      if (cmd_ready_o) begin
        done = 1;
      end else begin
        if (rdata_valid_o) nbeats++;
        if (rdata_last_o) nlast++;
        step();
      end
    end
    check("os_done_idle", 64'(done), 1);
    check("os_tail_beats", 64'(nbeats), 5);
    check("os_last_once", 64'(nlast), 1);
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;

    // Address wrap and unaligned start address
    run_read(32'hFFFF_FFC0, 1, 32'hFFFF_FFC0);
    run_read(32'h0000_1013, 0, 32'h0000_1000);

    // Reset in the middle of a read burst
    send_cmd(32'h0000_5000, 3, 1'b0);
    mem_gnt_i = 1'b1; rdata_ready_i = 1'b1;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (mem_req_o && mem_gnt_i) n++;
      step();
    end
    check("mid_grants", 64'(n), 2);
    rst_i = 1'b1; mem_rvalid_i = 1'b1; wdata_i = '1; mem_rdata_i = '1;
    step();
    #1;
    check("mid_rst_outs", 64'(any_out()), 0);
    rst_i = 1'b0; wdata_i = '0; mem_gnt_i = 1'b0;
    step();
    #1;
    check("late_rsp_rready", 64'(mem_rready_o), 1);
    check("late_rsp_drop", 64'(rdata_valid_o), 0);
    check("late_idle", 64'(cmd_ready_o), 1);
    check("late_noreq", 64'(mem_req_o), 0);
    step();
    mem_rvalid_i = 1'b0;
    run_read(32'h0000_2000, 0, 32'h0000_2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_island_burst_issuer.md
Name: memory_island_burst_issuer

Overview:
- Upstream stage for one wide port of the rready-capable memory island core wrapper.
- Accepts a burst command (start address, beat count, direction) plus a write-data stream.
- Issues one req/gnt transaction per beat at consecutive wide-word addresses.
- Forwards read responses with a last flag, swallows write responses, and signals write-burst completion.

Parameters:
AddrWidth, 32, byte address width
DataWidth, 512, wide data width in bits (power of 2, >= 8)
MaxBeats, 256, max beats per burst (power of 2)
MaxOutstanding, 4, max granted-but-unanswered beats
LenWidth, $clog2(MaxBeats), derived, do not override
StrbWidth, DataWidth/8, derived, do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  burst command valid
cmd_ready_o  out  1  burst command ready
cmd_addr_i  in  AddrWidth  start byte address
cmd_len_i  in  LenWidth  beats minus one
cmd_we_i  in  1  1 = write burst
wdata_valid_i  in  1  write beat valid
wdata_ready_o  out  1  write beat ready
wdata_i  in  DataWidth  write beat data
wstrb_i  in  StrbWidth  write beat strobe
mem_req_o  out  1  request to wide port
mem_gnt_i  in  1  grant
mem_addr_o  out  AddrWidth  beat address
mem_we_o  out  1  write enable
mem_wdata_o  out  DataWidth  write data
mem_strb_o  out  StrbWidth  write strobe
mem_rvalid_i  in  1  response valid
mem_rready_o  out  1  response ready
mem_rdata_i  in  DataWidth  response data
rdata_valid_o  out  1  read beat valid
rdata_ready_i  in  1  read beat ready
rdata_o  out  DataWidth  read beat data
rdata_last_o  out  1  final read beat of burst
wdone_valid_o  out  1  write burst complete
wdone_ready_i  in  1  completion accepted

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- On reset, all outputs are 0. State returns to IDLE and all counters clear, including when reset occurs mid-burst.
- After reset, any response arriving in IDLE is accepted (mem_rready_o=1) and dropped.
- FSM states: IDLE, ISSUE, DRAIN, WDONE.
  - IDLE: cmd_ready_o=1. On handshake, latch cmd_addr_i with the low $clog2(StrbWidth) bits zeroed, latch len and we, clear counters, go to ISSUE. mem_req_o is earliest the next cycle.
  - ISSUE: mem_req_o = (~we | wdata_valid_i) & (outstanding < MaxOutstanding).
  - mem_we_o equals the latched we. mem_wdata_o and mem_strb_o are wdata_i and wstrb_i.
  - wdata_ready_o = we & mem_req_o & mem_gnt_i.
  - Once raised, mem_req_o and its payload stay stable until gnt.
  - On req&gnt: address += StrbWidth (wraps mod 2^AddrWidth), issue count increments. If issue count == len, go to DRAIN.
  - DRAIN: no requests. When the response count reaches len+1, reads go to IDLE and writes go to WDONE.
  - WDONE: wdone_valid_o=1 until wdone_ready_i, then go to IDLE.
- Single-beat burst (len=0): ISSUE lasts until one grant, then goes to DRAIN.
- Responses are handled in both ISSUE and DRAIN:
  - Read: rdata_valid_o = mem_rvalid_i and mem_rready_o = rdata_ready_i, combinationally (zero latency). rdata_o = mem_rdata_i. rdata_last_o = rdata_valid_o & (response count == len).
  - Write: mem_rready_o=1 and rdata_valid_o=0; responses are discarded but counted.
  - A final response consumed in ISSUE (impossible before the last grant) needs no special case.
- Outstanding counter: +1 on req&gnt, -1 on rvalid&rready, unchanged when both occur in the same cycle. Width is $clog2(MaxOutstanding+1). Never exceeds MaxOutstanding.
- Response and issue counters are LenWidth+1 bits wide. Bursts are strictly serialised: no new command until the previous burst finishes, including wdone.

Test Plan:
- Read, addr=0x1000, len=3, always gnt, 1-cycle rvalid, rdata_ready=1 -> mem_addr_o = 0x1000, 0x1040, 0x1080, 0x10C0; 4 rdata beats; last only on the 4th; IDLE after.
- Write, len=1, wdata_valid low for 3 cycles then high -> no mem_req_o until wdata valid; 2 grants; both responses dropped; wdone_valid_o held until wdone_ready_i; cmd_ready_o stays 0 until then.
- MaxOutstanding=4, read len=7, gnt=1, responses withheld -> exactly 4 grants, then mem_req_o=0. Releasing one response yields exactly one further grant.
- Backpressure, rdata_ready_i=0 for 5 cycles with mem_rvalid_i=1 -> mem_rready_o=0 and the beat is held. Same-cycle gnt and response leaves outstanding unchanged.
- addr=0xFFFF_FFC0, len=1 -> second beat addr=0x0000_0000. Unaligned cmd addr 0x1013 -> first beat 0x1000.
- Assert rst_i after 2 of 4 read grants -> next cycle all outputs 0, IDLE. Late responses are dropped. A new command works normally.
